// File: rtl/hex_display_arbiter_pkg.sv
// rtl/hex_display_arbiter_pkg.sv - shared constants and types for the hex display arbiter
package hex_display_pkg;

  localparam int NCH = 4;

  // Segment patterns indexed [0:6]; bit 0 is segment g, bit 6 is segment a.
  localparam logic [0:6] SEG_BLANK = 7'b0000000;

  localparam logic [0:6] SEG_DIGIT [0:9] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111   // 9
  };

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

endpackage

// File: rtl/hex_display_arbiter_if.sv
// rtl/hex_display_arbiter_if.sv - requester handshake and display pins bundle
interface hex_display_if;

  logic [3:0]  REQ_VALID;
  logic [15:0] REQ_DATA;
  logic [3:0]  REQ_READY;
  logic [0:6]  HEX0;
  logic [0:6]  HEX1;
  logic [3:0]  ACTIVE;
  logic        BUSY;

  // Requesters and the board side of the display.
  modport master (
    output REQ_VALID, REQ_DATA,
    input  REQ_READY, HEX0, HEX1, ACTIVE, BUSY
  );

  // The arbiter itself.
  modport slave (
    input  REQ_VALID, REQ_DATA,
    output REQ_READY, HEX0, HEX1, ACTIVE, BUSY
  );

endinterface

// File: rtl/hex_display_arbiter_bcd_seg_decoder.sv
// rtl/hex_display_arbiter_bcd_seg_decoder.sv - 4-bit value to tens/units seven-segment patterns
module bcd_seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] value,
  output logic [0:6] hex1,
  output logic [0:6] hex0
);

  // Values 10..15 show a leading 1 and the remainder in the units digit.
  always_comb begin
    hex1 = SEG_BLANK;
    hex0 = SEG_BLANK;
    if (value < 4'd10) begin
      hex1 = SEG_DIGIT[0];
      hex0 = SEG_DIGIT[value];
    end else begin
      hex1 = SEG_DIGIT[1];
      hex0 = SEG_DIGIT[value - 4'd10];
    end
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// rtl/hex_display_arbiter.sv - round-robin sharing of one two-digit display among four requesters
module hex_display_arbiter
  import hex_display_pkg::*;
#(
  parameter int DWELL = 50_000_000
) (
  input  logic          CLOCK_50,
  input  logic          RESET,
  hex_display_if.slave  bus
);

  localparam int              CW       = $clog2(DWELL + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [3:0]       value_q, value_d;
  logic [NCH-1:0]   active_q, active_d;
  logic             busy_q, busy_d;
  logic [0:6]       hex0_q, hex0_d;
  logic [0:6]       hex1_q, hex1_d;

  logic             arb_cycle;
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic [1:0]       cand;
  logic [NCH-1:0]   grant_oh;
  logic             accept;
  logic [0:6]       dec_hex1, dec_hex0;

  // Round-robin pick: first valid channel searching upward from last_grant + 1.
  always_comb begin
    arb_cycle   = (state_q == IDLE) || (count_q == CNT_LAST);
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NCH; i++) begin
      cand = last_grant_q + 2'(i);
      if (!grant_found && bus.REQ_VALID[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_oh      = grant_found ? (4'b0001 << grant_idx) : '0;
    // Held off during reset so no transfer is signalled while flops are cleared.
    accept        = arb_cycle && grant_found && !RESET;
    bus.REQ_READY = accept ? grant_oh : '0;
  end

  // Decode the value that will be latched this cycle so the segments land with ACTIVE.
  bcd_seg_decoder u_dec (
    .value (value_d),
    .hex1  (dec_hex1),
    .hex0  (dec_hex0)
  );

  // Next-state: accept reloads the dwell; otherwise count out the dwell and fall to IDLE.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    value_d      = value_q;
    active_d     = active_q;
    busy_d       = busy_q;
    if (accept) begin
      value_d      = bus.REQ_DATA[{grant_idx, 2'b00} +: 4];
      active_d     = grant_oh;
      last_grant_d = grant_idx;
      count_d      = '0;
      busy_d       = 1'b1;
      state_d      = SHOW;
    end else if (state_q == SHOW) begin
      if (count_q == CNT_LAST) begin
        state_d  = IDLE;
        count_d  = '0;
        active_d = '0;
        busy_d   = 1'b0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
    hex1_d = accept ? dec_hex1 : hex1_q;
    hex0_d = accept ? dec_hex0 : hex0_q;
  end

  // FSM and output registers; last_grant resets to 3 so channel 0 wins first.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      count_q      <= '0;
      last_grant_q <= 2'd3;
      value_q      <= '0;
      active_q     <= '0;
      busy_q       <= 1'b0;
      hex0_q       <= SEG_BLANK;
      hex1_q       <= SEG_BLANK;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      value_q      <= value_d;
      active_q     <= active_d;
      busy_q       <= busy_d;
      hex0_q       <= hex0_d;
      hex1_q       <= hex1_d;
    end
  end

  assign bus.HEX0   = hex0_q;
  assign bus.HEX1   = hex1_q;
  assign bus.ACTIVE = active_q;
  assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb/tb_hex_display_arbiter.sv - directed self-checking bench for hex_display_arbiter
module tb_hex_display_arbiter;

  localparam int DWELL = 4;

  logic CLOCK_50 = 1'b0;
  logic RESET;

  hex_display_if bus ();

  hex_display_arbiter #(.DWELL(DWELL)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_disp(input string tag, input logic [0:6] h1, input logic [0:6] h0,
                            input logic [3:0] act, input logic busy);
    check({tag, "_hex1"}, 16'(bus.HEX1), 16'(h1));
    check({tag, "_hex0"}, 16'(bus.HEX0), 16'(h0));
    check({tag, "_active"}, 16'(bus.ACTIVE), 16'(act));
    check({tag, "_busy"}, 16'(bus.BUSY), 16'(busy));
  endtask

  // Walks dwell counts 0..DWELL-2, ending on the arbitration cycle.
  task automatic run_dwell(input string tag);
    for (int j = 0; j < DWELL - 1; j++) begin
      check({tag, "_dwell_ready"}, 16'(bus.REQ_READY), 16'h0);
      check({tag, "_dwell_busy"}, 16'(bus.BUSY), 16'h1);
      tick();
    end
  endtask

  logic [0:6] exp_h1 [4];
  logic [0:6] exp_h0 [4];
  int         order  [4];

  initial begin
    bus.REQ_VALID = '0;
    bus.REQ_DATA  = '0;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    settle();

    // Reset state
    check_disp("reset", 7'b0000000, 7'b0000000, 4'b0000, 1'b0);
    check("reset_ready", 16'(bus.REQ_READY), 16'h0);

    // Contention: data 0, 9, 10, 15 on channels 0..3
    exp_h1 = '{7'b0111111, 7'b0111111, 7'b0000110, 7'b0000110};
    exp_h0 = '{7'b0111111, 7'b1101111, 7'b0111111, 7'b1101101};
    bus.REQ_DATA  = {4'd15, 4'd10, 4'd9, 4'd0};
    bus.REQ_VALID = 4'b1111;
    settle();
    for (int k = 0; k < 4; k++) begin
      check("cont_ready", 16'(bus.REQ_READY), 16'(4'b0001 << k));
      tick();
      bus.REQ_VALID[k] = 1'b0;
      settle();
      check_disp("cont", exp_h1[k], exp_h0[k], 4'(4'b0001 << k), 1'b1);
      run_dwell("cont");
    end
    check("cont_last_ready", 16'(bus.REQ_READY), 16'h0);
    tick();
    check_disp("cont_idle", 7'b0000110, 7'b1101101, 4'b0000, 1'b0);

    // Single request: channel 2, value 13
    bus.REQ_DATA  = 16'h0D00;
    bus.REQ_VALID = 4'b0100;
    settle();
    check("single_ready", 16'(bus.REQ_READY), 16'b0100);
    tick();
    bus.REQ_VALID = 4'b0000;
    settle();
    check_disp("single", 7'b0000110, 7'b1001111, 4'b0100, 1'b1);
    run_dwell("single");
    check("single_last_ready", 16'(bus.REQ_READY), 16'h0);
    tick();
    check_disp("single_idle", 7'b0000110, 7'b1001111, 4'b0000, 1'b0);

    // Fairness: serve channel 1 (value 2), then 0, 1, 3 contend
    bus.REQ_DATA  = 16'h0020;
    bus.REQ_VALID = 4'b0010;
    settle();
    check("fair_pre_ready", 16'(bus.REQ_READY), 16'b0010);
    tick();
    bus.REQ_VALID = 4'b0000;
    settle();
    check_disp("fair_pre", 7'b0111111, 7'b1011011, 4'b0010, 1'b1);
    run_dwell("fair_pre");
    tick();
    order  = '{3, 0, 1, 0};
    exp_h1 = '{7'b0111111, 7'b0111111, 7'b0111111, 7'b0000000};
    exp_h0 = '{7'b1111111, 7'b1101101, 7'b0000111, 7'b0000000};
    bus.REQ_DATA  = {4'd8, 4'd0, 4'd7, 4'd5};
    bus.REQ_VALID = 4'b1011;
    settle();
    for (int k = 0; k < 3; k++) begin
      check("fair_ready", 16'(bus.REQ_READY), 16'(4'b0001 << order[k]));
      tick();
      bus.REQ_VALID[order[k]] = 1'b0;
      settle();
      check_disp("fair", exp_h1[k], exp_h0[k], 4'(4'b0001 << order[k]), 1'b1);
      run_dwell("fair");
    end
    tick();

    // Withdrawal: channel 1 valid only mid-dwell of a channel 0 display (value 3)
    bus.REQ_DATA  = 16'h0003;
    bus.REQ_VALID = 4'b0001;
    settle();
    check("wd_ready", 16'(bus.REQ_READY), 16'b0001);
    tick();
    bus.REQ_VALID = 4'b0000;
    settle();
    check_disp("wd", 7'b0111111, 7'b1001111, 4'b0001, 1'b1);
    tick();
    bus.REQ_VALID = 4'b0010;
    settle();
    check("wd_mid_ready", 16'(bus.REQ_READY), 16'h0);
    tick();
    bus.REQ_VALID = 4'b0000;
    tick();
    settle();
    check("wd_last_ready", 16'(bus.REQ_READY), 16'h0);
    check("wd_last_busy", 16'(bus.BUSY), 16'h1);
    tick();
    check_disp("wd_idle", 7'b0111111, 7'b1001111, 4'b0000, 1'b0);
    tick();
    check("wd_idle2_ready", 16'(bus.REQ_READY), 16'h0);
    check("wd_idle2_busy", 16'(bus.BUSY), 16'h0);

    // Reset mid-dwell: channel 2 (value 4) shown, channels 0 (value 6) and 2 pending
    bus.REQ_DATA  = {4'd0, 4'd4, 4'd0, 4'd6};
    bus.REQ_VALID = 4'b0100;
    settle();
    check("rst_pre_ready", 16'(bus.REQ_READY), 16'b0100);
    tick();
    bus.REQ_VALID = 4'b0101;
    settle();
    check_disp("rst_pre", 7'b0111111, 7'b1100110, 4'b0100, 1'b1);
    tick();
    RESET = 1'b1;
    settle();
    check_disp("rst_mid", 7'b0000000, 7'b0000000, 4'b0000, 1'b0);
    check("rst_mid_ready", 16'(bus.REQ_READY), 16'h0);
    tick();
    RESET = 1'b0;
    settle();
    check("rst_post_ready", 16'(bus.REQ_READY), 16'b0001);
    tick();
    bus.REQ_VALID[0] = 1'b0;
    settle();
    check_disp("rst_post", 7'b0111111, 7'b1111101, 4'b0001, 1'b1);
    run_dwell("rst_post");
    check("rst_next_ready", 16'(bus.REQ_READY), 16'b0100);
    tick();
    bus.REQ_VALID = 4'b0000;
    settle();
    check_disp("rst_next", 7'b0111111, 7'b1100110, 4'b0100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
